vx_hw_itr_ras: RTL and testbench
================================

Name: VX_hw_itr_ras

Overview:
Per-warp hardware-interrupt return-address stack and context store for the execute stage.
- Keeps RAS_DEPTH return addresses per warp, plus one saved SIMT-scheduler return PC and an interrupt-pending flag per warp.
- Services pops and interrupt returns through a registered valid/ready response stage.
- Generalises the single RAS / single return-PC hand-off to N warps, configurable depth, overflow/underflow tracking and backpressure.

Parameters:
NUM_WARPS, 4, number of warp contexts (power of 2, >=2)
XLEN, 32, address width
RAS_DEPTH, 4, stack entries per warp (power of 2, >=2)
RET_HANDLER_ADDR, 32'h8000_0100, address returned on pop of an empty stack

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
push_valid  in  1  push return address (always accepted)
push_wid  in  log2(NUM_WARPS)  warp of push
push_addr  in  XLEN  address pushed (e.g. PC+4 of JAL/wspawn)
pop_valid  in  1  pop request
pop_wid  in  log2(NUM_WARPS)  warp of pop
pop_ready  out  1  pop accepted this cycle
sched_commit  in  1  save SIMT-scheduler return PC, set pending
sched_wid  in  log2(NUM_WARPS)  warp of commit
sched_pc  in  XLEN  PC to resume after handler
itr_ret_valid  in  1  interrupt-return request (shares pop_ready)
itr_ret_wid  in  log2(NUM_WARPS)  warp returning from handler
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_wid  out  log2(NUM_WARPS)  warp of response
rsp_pc  out  XLEN  popped address / resume PC / RET_HANDLER_ADDR
rsp_kind  out  1  0 = RAS pop, 1 = interrupt return
rsp_underflow  out  1  response served from empty stack/no pending
pending  out  NUM_WARPS  per-warp interrupt-pending bits
overflow  out  NUM_WARPS  sticky per-warp overflow bits

Behaviour:
Reset (async, reset_n=0):
- All depth counters and pointers 0; pending=0; overflow=0.
- rsp_valid=0, rsp_wid=0, rsp_pc=0, rsp_kind=0, rsp_underflow=0.
- Stack storage is not reset.

Stack organisation:
- Each warp stack is circular: top pointer tp (log2 RAS_DEPTH bits), depth counter d (0..RAS_DEPTH).

Push (applied at clk edge):
- Writes entry[tp+1 mod RAS_DEPTH], then tp<=tp+1.
- d<RAS_DEPTH: d<=d+1.
- d==RAS_DEPTH: oldest entry overwritten (wrap), d stays, overflow[wid]<=1 (sticky until reset).

Request arbitration and response stage:
- pop_ready = !rsp_valid || rsp_ready.
- itr_ret_valid has priority over pop_valid. The loser is not accepted; it holds its request.
- Accepted request loads the response register next edge: 1-cycle latency. rsp_valid stays high with stable fields until rsp_ready.

Accepted pop:
- d>0: rsp_pc=entry[tp], tp<=tp-1, d<=d-1, rsp_underflow=0.
- d==0: rsp_pc=RET_HANDLER_ADDR, rsp_underflow=1, state unchanged.

Accepted itr_ret:
- pending[wid]=1: rsp_pc=saved sched PC, pending<=0, rsp_kind=1, rsp_underflow=0.
- Otherwise: rsp_pc=RET_HANDLER_ADDR, rsp_underflow=1.

sched_commit:
- Saves sched_pc and sets pending[wid].
- If pending is already set, the PC is overwritten.
- Commit and itr_ret accepted for the same warp in the same cycle: the response returns the old PC; pending ends 1 with the new PC.

Push and pop accepted for the same warp in the same cycle:
- Response returns the old top; pushed address replaces that slot.
- tp and d unchanged. Overflow is not set, even when full.

Ordering across warps: different warps are fully independent in one cycle.

Reset mid-transaction: any held response is dropped.

Test Plan:
1. Reset, push 0x100,0x104,0x108 to warp 2, three pops with rsp_ready=1 -> rsp_pc 0x108,0x104,0x100 on consecutive cycles after 1-cycle latency; fourth pop -> 0x8000_0100, rsp_underflow=1.
2. Push 0x10..0x14 (5 entries) to warp 1 -> overflow=4'b0010; pops return 0x14,0x13,0x12,0x11 then underflow.
3. Hold rsp_ready=0 with pop to warp 0 pending -> rsp fields stable, pop_ready=0, second pop not accepted; release -> second response next cycle.
4. sched_commit warp 3 pc=0x2000, then itr_ret warp 3 -> rsp_kind=1, rsp_pc=0x2000, pending[3] 1 -> 0; repeat itr_ret -> underflow=1, pc=0x8000_0100.
5. Same-cycle push 0xA0 and pop warp 0 with top=0x50 -> rsp_pc=0x50, next pop returns 0xA0, depth unchanged.
6. Assert reset_n low while rsp_valid=1 and depths nonzero -> rsp_valid=0, pending=0, overflow=0 immediately; pop after release -> underflow.

Source files
------------

// File: rtl/vx_hw_itr_ras_if.sv
// rtl/vx_hw_itr_ras_if.sv - request/response bundle for the per-warp interrupt return-address stack
// Purpose: groups push, pop, scheduler-commit, interrupt-return and response signals.
// Ports (master = requester/consumer, slave = vx_hw_itr_ras):
//   push_valid/push_wid/push_addr        : return-address push
//   pop_valid/pop_wid, pop_ready         : pop request and acceptance
//   sched_commit/sched_wid/sched_pc      : save resume PC, set pending
//   itr_ret_valid/itr_ret_wid            : interrupt return request
//   rsp_valid/rsp_ready/rsp_wid/rsp_pc/rsp_kind/rsp_underflow : response stage
//   pending/overflow                     : per-warp status
interface vx_hw_itr_ras_if #(
  parameter int NUM_WARPS = 4,
  parameter int XLEN      = 32
);
  localparam int WW = $clog2(NUM_WARPS);

  logic                 push_valid;
  logic [WW-1:0]        push_wid;
  logic [XLEN-1:0]      push_addr;
  logic                 pop_valid;
  logic [WW-1:0]        pop_wid;
  logic                 pop_ready;
  logic                 sched_commit;
  logic [WW-1:0]        sched_wid;
  logic [XLEN-1:0]      sched_pc;
  logic                 itr_ret_valid;
  logic [WW-1:0]        itr_ret_wid;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WW-1:0]        rsp_wid;
  logic [XLEN-1:0]      rsp_pc;
  logic                 rsp_kind;
  logic                 rsp_underflow;
  logic [NUM_WARPS-1:0] pending;
  logic [NUM_WARPS-1:0] overflow;

  modport master (
    output push_valid, push_wid, push_addr,
    output pop_valid, pop_wid,
    output sched_commit, sched_wid, sched_pc,
    output itr_ret_valid, itr_ret_wid,
    output rsp_ready,
    input  pop_ready,
    input  rsp_valid, rsp_wid, rsp_pc, rsp_kind, rsp_underflow,
    input  pending, overflow
  );

  modport slave (
    input  push_valid, push_wid, push_addr,
    input  pop_valid, pop_wid,
    input  sched_commit, sched_wid, sched_pc,
    input  itr_ret_valid, itr_ret_wid,
    input  rsp_ready,
    output pop_ready,
    output rsp_valid, rsp_wid, rsp_pc, rsp_kind, rsp_underflow,
    output pending, overflow
  );
endinterface

// File: rtl/vx_hw_itr_ras.sv
// rtl/vx_hw_itr_ras.sv - per-warp return-address stack and interrupt context store
// Purpose: RAS_DEPTH-entry circular return-address stack per warp, one saved
//   scheduler resume PC plus pending flag per warp, and a registered
//   valid/ready response stage shared by pops and interrupt returns.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : vx_hw_itr_ras_if slave modport (requests, response, status)
module vx_hw_itr_ras #(
  parameter int              NUM_WARPS        = 4,
  parameter int              XLEN             = 32,
  parameter int              RAS_DEPTH        = 4,
  parameter logic [XLEN-1:0] RET_HANDLER_ADDR = XLEN'(32'h8000_0100)
) (
  input  logic             clk,
  input  logic             reset_n,
  vx_hw_itr_ras_if.slave   bus
);
  localparam int WW = $clog2(NUM_WARPS);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] FULL = DW'(RAS_DEPTH);

  // Storage: deliberately not reset.
  logic [XLEN-1:0] ras_q [NUM_WARPS][RAS_DEPTH];
  logic [XLEN-1:0] spc_q [NUM_WARPS];

  logic [NUM_WARPS-1:0][PW-1:0] tp_q, tp_d;
  logic [NUM_WARPS-1:0][DW-1:0] d_q, d_d;
  logic [NUM_WARPS-1:0]         pending_q, pending_d;
  logic [NUM_WARPS-1:0]         overflow_q, overflow_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [WW-1:0]   rsp_wid_q, rsp_wid_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic            rsp_kind_q, rsp_kind_d;
  logic            rsp_uf_q, rsp_uf_d;

  logic          pop_ready;
  logic          acc_itr;
  logic          acc_pop;
  logic          pop_hit;
  logic          collide;
  logic [PW-1:0] wr_idx;

  // The response register frees up when empty or drained this cycle.
  assign pop_ready = !rsp_valid_q || bus.rsp_ready;
  // Interrupt return wins; a losing pop simply stays asserted.
  assign acc_itr   = bus.itr_ret_valid && pop_ready;
  assign acc_pop   = bus.pop_valid && !bus.itr_ret_valid && pop_ready;
  assign pop_hit   = acc_pop && (d_q[bus.pop_wid] != '0);
  // Push and non-empty pop on the same warp: pushed address replaces the
  // current top in place, so pointer and depth stay put.
  assign collide   = bus.push_valid && pop_hit && (bus.push_wid == bus.pop_wid);
  assign wr_idx    = collide ? tp_q[bus.push_wid] : tp_q[bus.push_wid] + PW'(1);

  always_comb begin
    tp_d        = tp_q;
    d_d         = d_q;
    pending_d   = pending_q;
    overflow_d  = overflow_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wid_d   = rsp_wid_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_kind_d  = rsp_kind_q;
    rsp_uf_d    = rsp_uf_q;

    if (bus.rsp_ready) rsp_valid_d = 1'b0;

    if (bus.push_valid && !collide) begin
      tp_d[bus.push_wid] = tp_q[bus.push_wid] + PW'(1);
      // Full stack wraps onto the oldest entry; depth saturates.
      if (d_q[bus.push_wid] == FULL) overflow_d[bus.push_wid] = 1'b1;
      else                           d_d[bus.push_wid] = d_q[bus.push_wid] + DW'(1);
    end

    if (pop_hit && !collide) begin
      tp_d[bus.pop_wid] = tp_q[bus.pop_wid] - PW'(1);
      d_d[bus.pop_wid]  = d_q[bus.pop_wid] - DW'(1);
    end

    if (acc_pop) begin
      rsp_valid_d = 1'b1;
      rsp_wid_d   = bus.pop_wid;
      rsp_kind_d  = 1'b0;
      rsp_uf_d    = !pop_hit;
      rsp_pc_d    = pop_hit ? ras_q[bus.pop_wid][tp_q[bus.pop_wid]] : RET_HANDLER_ADDR;
    end

    if (acc_itr) begin
      rsp_valid_d = 1'b1;
      rsp_wid_d   = bus.itr_ret_wid;
      rsp_kind_d  = 1'b1;
      if (pending_q[bus.itr_ret_wid]) begin
        rsp_pc_d                     = spc_q[bus.itr_ret_wid];
        rsp_uf_d                     = 1'b0;
        pending_d[bus.itr_ret_wid]   = 1'b0;
      end else begin
        rsp_pc_d = RET_HANDLER_ADDR;
        rsp_uf_d = 1'b1;
      end
    end

    // Applied last so a same-cycle commit leaves the warp pending.
    if (bus.sched_commit) pending_d[bus.sched_wid] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tp_q        <= '0;
      d_q         <= '0;
      pending_q   <= '0;
      overflow_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wid_q   <= '0;
      rsp_pc_q    <= '0;
      rsp_kind_q  <= 1'b0;
      rsp_uf_q    <= 1'b0;
    end else begin
      tp_q        <= tp_d;
      d_q         <= d_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wid_q   <= rsp_wid_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_kind_q  <= rsp_kind_d;
      rsp_uf_q    <= rsp_uf_d;
    end
  end

  // Reads above see the pre-edge contents, giving old-value semantics for
  // same-cycle commit/return and push/pop on one warp.
  always_ff @(posedge clk) begin
    if (bus.push_valid)   ras_q[bus.push_wid][wr_idx] <= bus.push_addr;
    if (bus.sched_commit) spc_q[bus.sched_wid]        <= bus.sched_pc;
  end

  assign bus.pop_ready     = pop_ready;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_wid       = rsp_wid_q;
  assign bus.rsp_pc        = rsp_pc_q;
  assign bus.rsp_kind      = rsp_kind_q;
  assign bus.rsp_underflow = rsp_uf_q;
  assign bus.pending       = pending_q;
  assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_vx_hw_itr_ras.sv
// tb/tb_vx_hw_itr_ras.sv - directed scoreboard bench for vx_hw_itr_ras
module tb_vx_hw_itr_ras;
  localparam logic [31:0] RET = 32'h8000_0100;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vx_hw_itr_ras_if #(.NUM_WARPS(4), .XLEN(32)) bus ();

  vx_hw_itr_ras #(
    .NUM_WARPS(4), .XLEN(32), .RAS_DEPTH(4), .RET_HANDLER_ADDR(32'h8000_0100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    logic [1:0]  wid;
    logic [31:0] pc;
    logic        kind;
    logic        uf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void exp_push(input logic [1:0] w, input logic [31:0] pc,
                                   input logic k, input logic u);
    exp_t e;
    e.wid = w; e.pc = pc; e.kind = k; e.uf = u;
    sb.push_back(e);
  endfunction

  // Responses are checked at the moment they are handed off (valid && ready
  // just before the edge), then one clock passes and sampling happens #1 later.
  task automatic tick();
    exp_t e;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL rsp_unexpected: observed pc=%0h expected no response", bus.rsp_pc);
      end else begin
        e = sb.pop_front();
        chk("rsp_wid",  bus.rsp_wid,       e.wid);
        chk("rsp_pc",   bus.rsp_pc,        e.pc);
        chk("rsp_kind", bus.rsp_kind,      e.kind);
        chk("rsp_uf",   bus.rsp_underflow, e.uf);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [1:0] w, input logic [31:0] a);
    bus.push_valid = 1'b1; bus.push_wid = w; bus.push_addr = a;
    tick();
    bus.push_valid = 1'b0;
  endtask

  task automatic do_pop(input logic [1:0] w, input logic [31:0] pc, input logic u);
    exp_push(w, pc, 1'b0, u);
    bus.pop_valid = 1'b1; bus.pop_wid = w;
    tick();
    bus.pop_valid = 1'b0;
  endtask

  task automatic do_itr(input logic [1:0] w, input logic [31:0] pc, input logic u);
    exp_push(w, pc, 1'b1, u);
    bus.itr_ret_valid = 1'b1; bus.itr_ret_wid = w;
    tick();
    bus.itr_ret_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [1:0] w, input logic [31:0] pc);
    bus.sched_commit = 1'b1; bus.sched_wid = w; bus.sched_pc = pc;
    tick();
    bus.sched_commit = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.push_valid = 1'b0; bus.push_wid = '0; bus.push_addr = '0;
    bus.pop_valid = 1'b0; bus.pop_wid = '0;
    bus.sched_commit = 1'b0; bus.sched_wid = '0; bus.sched_pc = '0;
    bus.itr_ret_valid = 1'b0; bus.itr_ret_wid = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) tick();

    // Reset state
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_wid",   bus.rsp_wid, 0);
    chk("rst_rsp_pc",    bus.rsp_pc, 0);
    chk("rst_rsp_kind",  bus.rsp_kind, 0);
    chk("rst_rsp_uf",    bus.rsp_underflow, 0);
    chk("rst_pending",   bus.pending, 0);
    chk("rst_overflow",  bus.overflow, 0);
    chk("rst_pop_ready", bus.pop_ready, 1);
    reset_n = 1'b1;
    tick();

    // 1: LIFO order on warp 2, then underflow
    do_push(2, 32'h100);
    do_push(2, 32'h104);
    do_push(2, 32'h108);
    do_pop(2, 32'h108, 1'b0);
    do_pop(2, 32'h104, 1'b0);
    do_pop(2, 32'h100, 1'b0);
    do_pop(2, RET, 1'b1);
    tick();

    // 2: overflow wrap on warp 1
    for (int i = 0; i < 5; i++) do_push(1, 32'h10 + i);
    chk("ovf_w1", bus.overflow, 4'b0010);
    for (int i = 4; i >= 1; i--) do_pop(1, 32'h10 + i, 1'b0);
    do_pop(1, RET, 1'b1);
    tick();

    // 3: backpressure holds the response and blocks the second pop
    do_push(0, 32'h30);
    do_push(0, 32'h31);
    bus.rsp_ready = 1'b0;
    exp_push(0, 32'h31, 1'b0, 1'b0);
    exp_push(0, 32'h30, 1'b0, 1'b0);
    bus.pop_valid = 1'b1; bus.pop_wid = 0;
    tick();
    chk("bp_valid0", bus.rsp_valid, 1);
    chk("bp_pc0",    bus.rsp_pc, 32'h31);
    chk("bp_ready0", bus.pop_ready, 0);
    tick();
    chk("bp_valid1", bus.rsp_valid, 1);
    chk("bp_pc1",    bus.rsp_pc, 32'h31);
    chk("bp_ready1", bus.pop_ready, 0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_ready2", bus.pop_ready, 1);
    tick();
    bus.pop_valid = 1'b0;
    tick();
    chk("bp_drained", bus.rsp_valid, 0);

    // 4: interrupt context save / return
    do_commit(3, 32'h2000);
    chk("pend_set", bus.pending, 4'b1000);
    do_itr(3, 32'h2000, 1'b0);
    chk("pend_clr", bus.pending, 4'b0000);
    do_itr(3, RET, 1'b1);
    tick();
    // itr_ret wins over a simultaneous pop; the pop is served next cycle
    do_commit(3, 32'h3000);
    exp_push(3, 32'h3000, 1'b1, 1'b0);
    exp_push(0, RET, 1'b0, 1'b1);
    bus.itr_ret_valid = 1'b1; bus.itr_ret_wid = 3;
    bus.pop_valid = 1'b1; bus.pop_wid = 0;
    tick();
    bus.itr_ret_valid = 1'b0;
    tick();
    bus.pop_valid = 1'b0;
    tick();
    // commit and return on the same warp in one cycle
    do_commit(3, 32'h4000);
    exp_push(3, 32'h4000, 1'b1, 1'b0);
    bus.itr_ret_valid = 1'b1; bus.itr_ret_wid = 3;
    bus.sched_commit = 1'b1; bus.sched_wid = 3; bus.sched_pc = 32'h5000;
    tick();
    bus.itr_ret_valid = 1'b0; bus.sched_commit = 1'b0;
    chk("pend_keep", bus.pending, 4'b1000);
    do_itr(3, 32'h5000, 1'b0);
    tick();
    chk("pend_clr2", bus.pending, 4'b0000);

    // 5: same-cycle push and pop on warp 0
    do_push(0, 32'h50);
    exp_push(0, 32'h50, 1'b0, 1'b0);
    bus.push_valid = 1'b1; bus.push_wid = 0; bus.push_addr = 32'hA0;
    bus.pop_valid = 1'b1; bus.pop_wid = 0;
    tick();
    bus.push_valid = 1'b0; bus.pop_valid = 1'b0;
    do_pop(0, 32'hA0, 1'b0);
    do_pop(0, RET, 1'b1);
    tick();

    // 6: reset while a response is held
    for (int i = 0; i < 5; i++) do_push(1, 32'h60 + i);
    do_commit(2, 32'h7000);
    chk("pre_rst_ovf",  bus.overflow, 4'b0010);
    chk("pre_rst_pend", bus.pending, 4'b0100);
    bus.rsp_ready = 1'b0;
    bus.pop_valid = 1'b1; bus.pop_wid = 1;
    tick();
    bus.pop_valid = 1'b0;
    chk("pre_rst_valid", bus.rsp_valid, 1);
    chk("pre_rst_pc",    bus.rsp_pc, 32'h64);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_pend",  bus.pending, 0);
    chk("mid_rst_ovf",   bus.overflow, 0);
    bus.rsp_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    do_pop(1, RET, 1'b1);
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
